// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// MC_BNE_EN adds the BNE state and opcode support.
package mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ALUC_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`ifdef MC_BNE_EN
    JUMP    = 4'd11,
    BNE     = 4'd12
`else
    JUMP    = 4'd11
`endif
  } statetype;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [ALUC_W-1:0] ALUC_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop and R-type funct to the ALU operation code.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [ALUOP_W-1:0] i_aluop,
  input  logic [FUNCT_W-1:0] i_funct,
  output logic [ALUC_W-1:0]  o_alucontrol
);

  always_comb begin
    o_alucontrol = ALUC_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALUC_ADD;
      ALUOP_SUB: o_alucontrol = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alucontrol = ALUC_ADD;
          FN_SUB:  o_alucontrol = ALUC_SUB;
          FN_AND:  o_alucontrol = ALUC_AND;
          FN_OR:   o_alucontrol = ALUC_OR;
          FN_SLT:  o_alucontrol = ALUC_SLT;
          default: o_alucontrol = ALUC_ADD;
        endcase
      end
      default: o_alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath with a memory-ready handshake.
// Optional MC_BNE_EN adds bne support through a dedicated BNE state.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcen,
  output logic               irwrite,
  output logic               regwrite,
  output logic               memwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               alusrca,
  output logic [SEL_W-1:0]   alusrcb,
  output logic [SEL_W-1:0]   pcsrc,
  output logic [ALUC_W-1:0]  alucontrol,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  statetype            r_state;
  statetype            w_next;
  logic                w_ready;
  logic                w_pcwrite;
  logic                w_branch;
  logic                w_branch_ne;
  logic                w_irwrite;
  logic                w_regwrite;
  logic                w_memwrite;
  logic                w_illegal;
  logic [ALUOP_W-1:0]  w_aluop;

  assign w_ready = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_next;
  end

  // Next-state and Moore output decode; every output defaults to 0.
  always_comb begin
    w_next      = FETCH;
    w_pcwrite   = 1'b0;
    w_branch    = 1'b0;
    w_branch_ne = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_memwrite  = 1'b0;
    w_illegal   = 1'b0;
    w_aluop     = ALUOP_ADD;
    iord        = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_REG;
    pcsrc       = PCSRC_ALU;
    case (r_state)
      FETCH: begin
        alusrcb   = SRCB_FOUR;
        w_irwrite = w_ready;
        w_pcwrite = w_ready;
        w_next    = w_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH2;
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXECUTE;
          OP_BEQ:       w_next = BRANCH;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       w_next = BNE;
`endif
          default: begin
            w_illegal = 1'b1;
            w_next    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        w_next  = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord   = 1'b1;
        w_next = w_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
        w_next  = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsrc    = PCSRC_ALUOUT;
        w_branch = 1'b1;
      end
`ifdef MC_BNE_EN
      BNE: begin
        alusrca     = 1'b1;
        w_aluop     = ALUOP_SUB;
        pcsrc       = PCSRC_ALUOUT;
        w_branch_ne = 1'b1;
      end
`endif
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        w_next  = ADDIWB;
      end
      ADDIWB: w_regwrite = 1'b1;
      JUMP: begin
        pcsrc     = PCSRC_JUMP;
        w_pcwrite = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end

  // Write enables are held low for the whole time reset is asserted.
  assign pcen       = reset & (w_pcwrite | (w_branch & zero) | (w_branch_ne & ~zero));
  assign irwrite    = reset & w_irwrite;
  assign regwrite   = reset & w_regwrite;
  assign memwrite   = reset & w_memwrite;
  assign illegal_op = reset & w_illegal;
  assign state      = r_state;

  mc_aludec u_aludec (
    .i_aluop      (w_aluop),
    .i_funct      (funct),
    .o_alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed instruction sequences, per-cycle output checks.
module tb_mc_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    string name;
    outs_t exp;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
    .memwrite(memwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Expected outputs for a state, taken from the per-state control table.
  function automatic outs_t model(statetype st, logic rdy, logic z, logic rst_n,
                                  logic ill, logic [2:0] alu);
    outs_t o;
    o = '0;
    o.st = st;
    o.alucontrol = 3'b010;
    case (st)
      FETCH:   begin o.alusrcb = 2'b01; o.irwrite = rdy; o.pcen = rdy; end
      DECODE:  begin o.alusrcb = 2'b11; o.illegal_op = ill; end
      MEMADR:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      MEMRD:   o.iord = 1'b1;
      MEMWB:   begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
      MEMWR:   begin o.iord = 1'b1; o.memwrite = 1'b1; end
      EXECUTE: begin o.alusrca = 1'b1; o.alucontrol = alu; end
      ALUWB:   begin o.regdst = 1'b1; o.regwrite = 1'b1; end
      BRANCH:  begin o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
`ifdef MC_BNE_EN
      BNE:     begin o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = ~z; end
`endif
      ADDIEX:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      ADDIWB:  o.regwrite = 1'b1;
      JUMP:    begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
      default: ;
    endcase
    if (!rst_n) begin
      o.pcen = 1'b0; o.irwrite = 1'b0; o.regwrite = 1'b0;
      o.memwrite = 1'b0; o.illegal_op = 1'b0;
    end
    return o;
  endfunction

  // Push the expectation for the current cycle, then advance one clock.
  task automatic step(input string nm, input statetype st,
                      input logic ill = 1'b0, input logic [2:0] alu = 3'b010);
    item_t it;
    it.name = nm;
    it.exp  = model(st, mem_ready, zero, reset, ill, alu);
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every cycle that has an outstanding expectation.
  always @(negedge clk) begin
    item_t it;
    outs_t act;
    if (sb.size() > 0) begin
      it  = sb.pop_front();
      act = {state, pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
             alusrca, alusrcb, pcsrc, alucontrol, illegal_op};
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got st=%0d pcen=%b ir=%b rw=%b mw=%b iord=%b m2r=%b rdst=%b sa=%b sb=%b pcs=%b alu=%b ill=%b, expected st=%0d pcen=%b ir=%b rw=%b mw=%b iord=%b m2r=%b rdst=%b sa=%b sb=%b pcs=%b alu=%b ill=%b",
                 it.name, act.st, act.pcen, act.irwrite, act.regwrite, act.memwrite,
                 act.iord, act.memtoreg, act.regdst, act.alusrca, act.alusrcb,
                 act.pcsrc, act.alucontrol, act.illegal_op,
                 it.exp.st, it.exp.pcen, it.exp.irwrite, it.exp.regwrite,
                 it.exp.memwrite, it.exp.iord, it.exp.memtoreg, it.exp.regdst,
                 it.exp.alusrca, it.exp.alusrcb, it.exp.pcsrc, it.exp.alucontrol,
                 it.exp.illegal_op);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; op = OP_LW; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    step("rst0", FETCH);
    step("rst1", FETCH);
    reset = 1'b1;

    // lw, ready high: 5 cycles
    step("lw.fetch", FETCH);
    step("lw.dec", DECODE);
    step("lw.adr", MEMADR);
    step("lw.rd", MEMRD);
    step("lw.wb", MEMWB);

    // sw with FETCH stalled 3 cycles
    op = OP_SW; mem_ready = 1'b0;
    step("sw.stall0", FETCH);
    step("sw.stall1", FETCH);
    step("sw.stall2", FETCH);
    mem_ready = 1'b1;
    step("sw.fetch", FETCH);
    step("sw.dec", DECODE);
    step("sw.adr", MEMADR);
    step("sw.wr", MEMWR);

    // R-type sub
    op = OP_RTYPE; funct = FN_SUB;
    step("sub.fetch", FETCH);
    step("sub.dec", DECODE);
    step("sub.ex", EXECUTE, 1'b0, 3'b110);
    step("sub.wb", ALUWB);

    // R-type slt
    funct = FN_SLT;
    step("slt.fetch", FETCH);
    step("slt.dec", DECODE);
    step("slt.ex", EXECUTE, 1'b0, 3'b111);
    step("slt.wb", ALUWB);

    // R-type and, or, and an unknown funct
    funct = FN_AND;
    step("and.fetch", FETCH);
    step("and.dec", DECODE);
    step("and.ex", EXECUTE, 1'b0, 3'b000);
    step("and.wb", ALUWB);
    funct = FN_OR;
    step("or.fetch", FETCH);
    step("or.dec", DECODE);
    step("or.ex", EXECUTE, 1'b0, 3'b001);
    step("or.wb", ALUWB);
    funct = 6'b111000;
    step("fnx.fetch", FETCH);
    step("fnx.dec", DECODE);
    step("fnx.ex", EXECUTE, 1'b0, 3'b010);
    step("fnx.wb", ALUWB);

    // beq taken and not taken
    op = OP_BEQ; zero = 1'b1;
    step("beqt.fetch", FETCH);
    step("beqt.dec", DECODE);
    step("beqt.br", BRANCH);
    zero = 1'b0;
    step("beqn.fetch", FETCH);
    step("beqn.dec", DECODE);
    step("beqn.br", BRANCH);

    // addi and j
    op = OP_ADDI;
    step("addi.fetch", FETCH);
    step("addi.dec", DECODE);
    step("addi.ex", ADDIEX);
    step("addi.wb", ADDIWB);
    op = OP_J;
    step("j.fetch", FETCH);
    step("j.dec", DECODE);
    step("j.jump", JUMP);

    // illegal opcode
    op = 6'b111111;
    step("ill.fetch", FETCH);
    step("ill.dec", DECODE, 1'b1);

    // bne: dedicated state when enabled, illegal otherwise
    op = OP_BNE; zero = 1'b0;
    step("bne.fetch", FETCH);
`ifdef MC_BNE_EN
    step("bne.dec", DECODE);
    step("bne.br", BNE);
    zero = 1'b1;
    step("bnez.fetch", FETCH);
    step("bnez.dec", DECODE);
    step("bnez.br", BNE);
    zero = 1'b0;
`else
    step("bne.dec", DECODE, 1'b1);
`endif

    // lw with MEMRD stalled one cycle, then reset asserted mid-MEMRD
    op = OP_LW;
    step("lws.fetch", FETCH);
    step("lws.dec", DECODE);
    step("lws.adr", MEMADR);
    mem_ready = 1'b0;
    step("lws.rd0", MEMRD);
    #2;
    reset = 1'b0;
    step("rstrd.async", FETCH);
    mem_ready = 1'b1;
    step("rstrd.hold", FETCH);
    reset = 1'b1;
    op = OP_J;
    step("rstrd.fetch", FETCH);
    step("rstrd.dec", DECODE);
    step("rstrd.jump", JUMP);
    step("rstrd.back", FETCH);

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control unit for the multi-cycle MIPS datapath.
- A Moore FSM sequences the shared memory, ALU, register file and PC across Fetch, Decode, Execute, Memory and Writeback cycles, with a memory-ready handshake on memory reads.
- It sits inside `top` beside the datapath. It takes opcode, funct and ALU zero from the datapath and drives all enables and mux selects.

Parameters:
- MEM_HANDSHAKE, 1: when 1, FETCH and MEMRD wait for mem_ready. When 0, mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instruction opcode, instr[31:26].
- funct  in  6  instruction funct field, instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory read data is valid this cycle.
- pcen  out  1  PC write enable, equal to pcwrite | (branch & zero).
- irwrite  out  1  instruction register write enable.
- regwrite  out  1  register file write enable.
- memwrite  out  1  data memory write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memtoreg  out  1  register write-data select: 1 = data register.
- regdst  out  1  destination register select: 1 = rd, 0 = rt.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alucontrol  out  3  ALU operation.
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- state  out  4  current state, for debug.

Behaviour:
- States (mc_pkg enum): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Reset:
  - state = FETCH.
  - pcen, irwrite, regwrite, memwrite and illegal_op are forced to 0 while reset is low.
  - Selects take their FETCH values.
  - Assertion mid-instruction aborts immediately; no partial write occurs after the edge.
- Outputs are Moore (a function of state only), except:
  - pcen depends on zero.
  - irwrite and pcwrite in FETCH are gated by mem_ready.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite = pcwrite = mem_ready.
  - Go to DECODE if mem_ready, else stay.
- DECODE: alusrca=0, alusrcb=11, aluop=00.
  - lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
  - Any other opcode: assert illegal_op and go to FETCH (instruction treated as a nop).
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1. Go to MEMWB when mem_ready, else stay.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Then FETCH.
- MEMWR: iord=1, memwrite=1 for exactly one cycle. Then FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Then ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Then FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Then FETCH.
- JUMP: pcsrc=10, pcwrite=1. Then FETCH.
- Any signal not listed for a state is 0.
- Latency with mem_ready tied high: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
- Each cycle of mem_ready=0 in FETCH or MEMRD adds one cycle.
- ALU decoder, with alucontrol combinational from aluop and funct:
  - aluop 00 -> 010 (add); 01 -> 110 (sub).
  - aluop 10 by funct: add 100000 -> 010; sub 100010 -> 110; and 100100 -> 000; or 100101 -> 001; slt 101010 -> 111; any other funct -> 010.
- Opcodes:
  - R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
  - bne 000101, only with the optional feature.
- Unreachable state encodings recover to FETCH on the next edge.

Optional Feature:
- Macro MC_BNE_EN.
- Defined:
  - Adds state BNE, reached from DECODE when op = 000101.
  - BNE drives the same outputs as BRANCH except pcen = pcwrite | (branch & ~zero).
  - BNE then goes to FETCH.
- Undefined: op 000101 is illegal (illegal_op pulse, return to FETCH).

Decomposition:
- mc_pkg holds:
  - the statetype enum;
  - opcode and funct localparams;
  - aluop and alusrcb/pcsrc encodings.
- One sub-module, mc_aludec (aluop, funct -> alucontrol), instantiated once.
- The FSM, next-state logic and output decode stay in mc_controller.

Test Plan:
- Reset: hold reset=0 for 2 cycles with mem_ready=1 -> state=FETCH; pcen=irwrite=regwrite=memwrite=0. Release -> irwrite=pcen=1 in the first cycle.
- lw, op=100011, mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. regwrite=1, memtoreg=1, regdst=0 only in cycle 5.
- sw with mem_ready=0 for 3 cycles in FETCH -> FETCH held 4 cycles with irwrite=0 until ready. Then memwrite=1 for exactly one cycle in MEMWR, iord=1.
- R-type sub and slt (funct 100010, 101010) -> alucontrol=110 and 111 in EXECUTE; regdst=1 in ALUWB. beq with zero=1 -> pcen=1, pcsrc=01; with zero=0 -> pcen=0.
- op=111111 -> illegal_op=1 for one cycle in DECODE, then FETCH, no write enables. With MC_BNE_EN, op=000101 and zero=0 -> pcen=1.
- reset asserted in MEMRD -> state=FETCH asynchronously; no regwrite asserted afterwards.
